// File: rtl/heap_op_dispatch.sv
// Heap op dispatcher: queues push/pop/set-base commands and issues them to a credit-limited heap unit.
// Optional statistics counters are enabled with `define HEAP_DISPATCH_STATS_EN.
module heap_op_dispatch #(
    parameter int unsigned PIPE_CYCLES = 4,
    parameter int unsigned QDEPTH      = 4,
    parameter int unsigned HEAP_CAP    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_v,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_data,
    output logic        out_v,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_vrd1,
    output logic [2:0]  out_vrd2,
    output logic [31:0] out_data,
    output logic [31:0] out_heap_addr,
    output logic [31:0] out_heap_size,
    input  logic        ret_v,
    output logic        err_v,
    output logic [4:0]  err_rd,
    output logic        busy,
    output logic [31:0] stat_push,
    output logic [31:0] stat_pop,
    output logic [31:0] stat_err
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(PIPE_CYCLES + 1);

    localparam logic [1:0] OpPush    = 2'b00;
    localparam logic [1:0] OpPop     = 2'b01;
    localparam logic [1:0] OpSetbase = 2'b10;
    localparam logic [1:0] OpNop     = 2'b11;

    typedef enum logic [1:0] {StRun, StDrain, StSetbase} state_e;

    state_e r_state, w_state_d;

    logic [1:0]  r_op_mem   [QDEPTH];
    logic [4:0]  r_rd_mem   [QDEPTH];
    logic [31:0] r_data_mem [QDEPTH];

    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_d;
    logic [IW-1:0] r_inflight, w_inflight_d;
    logic [31:0]   r_size, r_base;

    logic          w_full, w_empty, w_enq, w_deq, w_issue, w_err, w_load_base, w_ret;
    logic          w_credit_ok;
    logic [1:0]    w_head_op;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;

    assign w_full      = (r_count == CW'(QDEPTH));
    assign w_empty     = (r_count == '0);
    assign w_enq       = cmd_v && !w_full;
    assign w_head_op   = r_op_mem[r_rptr];
    assign w_head_rd   = r_rd_mem[r_rptr];
    assign w_head_data = r_data_mem[r_rptr];
    assign w_credit_ok = (r_inflight < IW'(PIPE_CYCLES));
    assign w_ret       = ret_v && (r_inflight != '0);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_op_mem[r_wptr]   <= cmd_op;
            r_rd_mem[r_wptr]   <= cmd_rd;
            r_data_mem[r_wptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun:     if (!w_empty && w_head_op == OpSetbase) w_state_d = StDrain;
            StDrain:   if (r_inflight == '0) w_state_d = StSetbase;
            StSetbase: w_state_d = StRun;
            default:   w_state_d = StRun;
        endcase
    end

    // Capacity/underflow errors bypass the credit check; set-base stalls at the head.
    always_comb begin
        w_deq       = 1'b0;
        w_issue     = 1'b0;
        w_err       = 1'b0;
        w_load_base = 1'b0;
        unique case (r_state)
            StRun: begin
                if (!w_empty) begin
                    unique case (w_head_op)
                        OpPush: begin
                            if (r_size == 32'(HEAP_CAP)) begin
                                w_deq = 1'b1;
                                w_err = 1'b1;
                            end else if (w_credit_ok) begin
                                w_deq   = 1'b1;
                                w_issue = 1'b1;
                            end
                        end
                        OpPop: begin
                            if (r_size == '0) begin
                                w_deq = 1'b1;
                                w_err = 1'b1;
                            end else if (w_credit_ok) begin
                                w_deq   = 1'b1;
                                w_issue = 1'b1;
                            end
                        end
                        OpNop:     w_deq = 1'b1;
                        OpSetbase: w_deq = 1'b0;
                        default:   w_deq = 1'b0;
                    endcase
                end
            end
            StSetbase: begin
                w_deq       = 1'b1;
                w_load_base = 1'b1;
            end
            default: begin
                w_deq = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_count_d = r_count;
        if (w_enq && !w_deq) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_enq && w_deq) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_comb begin
        w_inflight_d = r_inflight;
        if (w_issue && !w_ret) begin
            w_inflight_d = r_inflight + 1'b1;
        end else if (!w_issue && w_ret) begin
            w_inflight_d = r_inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_size     <= '0;
            r_base     <= '0;
        end else begin
            r_count    <= w_count_d;
            r_inflight <= w_inflight_d;
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            if (w_load_base) begin
                r_base <= w_head_data;
                r_size <= '0;
            end else if (w_issue) begin
                r_size <= (w_head_op == OpPush) ? r_size + 1'b1 : r_size - 1'b1;
            end
        end
    end

    logic        r_out_v, r_err_v, r_busy, r_cmd_ready;
    logic [4:0]  r_out_rd, r_err_rd;
    logic [2:0]  r_out_vrd1;
    logic [31:0] r_out_data, r_out_heap_addr, r_out_heap_size;

    // busy and cmd_ready are registered from next-state values so they track the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_v         <= 1'b0;
            r_err_v         <= 1'b0;
            r_busy          <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_out_rd        <= '0;
            r_err_rd        <= '0;
            r_out_vrd1      <= '0;
            r_out_data      <= '0;
            r_out_heap_addr <= '0;
            r_out_heap_size <= '0;
        end else begin
            r_out_v     <= w_issue;
            r_err_v     <= w_err;
            r_busy      <= (w_count_d != '0) || (w_inflight_d != '0) || (w_state_d != StRun);
            r_cmd_ready <= (w_count_d != CW'(QDEPTH));
            if (w_issue) begin
                r_out_rd        <= w_head_rd;
                r_out_vrd1      <= (w_head_op == OpPush) ? 3'b000 : 3'b001;
                r_out_data      <= (w_head_op == OpPush) ? w_head_data : 32'd0;
                r_out_heap_addr <= r_base;
                r_out_heap_size <= r_size;
            end
            if (w_err) r_err_rd <= w_head_rd;
        end
    end

    assign out_v         = r_out_v;
    assign out_rd        = r_out_rd;
    assign out_vrd1      = r_out_vrd1;
    assign out_vrd2      = 3'b000;
    assign out_data      = r_out_data;
    assign out_heap_addr = r_out_heap_addr;
    assign out_heap_size = r_out_heap_size;
    assign err_v         = r_err_v;
    assign err_rd        = r_err_rd;
    assign busy          = r_busy;
    assign cmd_ready     = r_cmd_ready;

`ifdef HEAP_DISPATCH_STATS_EN
    logic [31:0] r_stat_push, r_stat_pop, r_stat_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_push <= '0;
            r_stat_pop  <= '0;
            r_stat_err  <= '0;
        end else begin
            if (w_issue && w_head_op == OpPush) r_stat_push <= r_stat_push + 1'b1;
            if (w_issue && w_head_op == OpPop)  r_stat_pop  <= r_stat_pop + 1'b1;
            if (w_err)                          r_stat_err  <= r_stat_err + 1'b1;
        end
    end

    assign stat_push = r_stat_push;
    assign stat_pop  = r_stat_pop;
    assign stat_err  = r_stat_err;
`else
    assign stat_push = 32'd0;
    assign stat_pop  = 32'd0;
    assign stat_err  = 32'd0;
`endif

endmodule

// File: tb/tb_heap_op_dispatch.sv
// Directed self-checking bench for heap_op_dispatch (HEAP_CAP reduced to 8 to reach the full boundary).
module tb_heap_op_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_v = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [4:0]  cmd_rd = '0;
    logic [31:0] cmd_data = '0;
    logic        out_v;
    logic [4:0]  out_rd;
    logic [2:0]  out_vrd1, out_vrd2;
    logic [31:0] out_data, out_heap_addr, out_heap_size;
    logic        ret_v = 1'b0;
    logic        err_v;
    logic [4:0]  err_rd;
    logic        busy;
    logic [31:0] stat_push, stat_pop, stat_err;

    int checks = 0;
    int errors = 0;

    // Monitor counters, sampled at posedge (outputs still hold the previous cycle's values).
    int          mon_issue = 0;
    int          mon_err = 0;
    int          mon_excl = 0;
    logic [31:0] mon_size = '0;
    logic [31:0] mon_addr = '0;
    logic [31:0] mon_data = '0;
    logic [4:0]  mon_rd = '0;
    logic [2:0]  mon_vrd1 = '0;
    logic [4:0]  mon_err_rd = '0;
    logic        mon_clear = 1'b0;

    heap_op_dispatch #(
        .PIPE_CYCLES(4),
        .QDEPTH     (4),
        .HEAP_CAP   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_v        (cmd_v),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_data     (cmd_data),
        .out_v        (out_v),
        .out_rd       (out_rd),
        .out_vrd1     (out_vrd1),
        .out_vrd2     (out_vrd2),
        .out_data     (out_data),
        .out_heap_addr(out_heap_addr),
        .out_heap_size(out_heap_size),
        .ret_v        (ret_v),
        .err_v        (err_v),
        .err_rd       (err_rd),
        .busy         (busy),
        .stat_push    (stat_push),
        .stat_pop     (stat_pop),
        .stat_err     (stat_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_clear) begin
            mon_issue <= 0;
            mon_err   <= 0;
        end else begin
            if (out_v) begin
                mon_issue <= mon_issue + 1;
                mon_size  <= out_heap_size;
                mon_addr  <= out_heap_addr;
                mon_data  <= out_data;
                mon_rd    <= out_rd;
                mon_vrd1  <= out_vrd1;
            end
            if (err_v) begin
                mon_err    <= mon_err + 1;
                mon_err_rd <= err_rd;
            end
        end
        if (out_v && err_v) mon_excl <= mon_excl + 1;
    end

    task automatic enq(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] data);
        cmd_v    = 1'b1;
        cmd_op   = op;
        cmd_rd   = rd;
        cmd_data = data;
        @(negedge clk);
        cmd_v    = 1'b0;
    endtask

    task automatic ret_pulse();
        ret_v = 1'b1;
        @(negedge clk);
        ret_v = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_v     = 1'b0;
        ret_v     = 1'b0;
        mon_clear = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        @(negedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_v !== 1'b0 || err_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: out_v=%b err_v=%b required 0 0", out_v, err_v);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
        checks++;
        if (out_heap_size !== 32'd0 || out_heap_addr !== 32'd0 || out_rd !== 5'd0 ||
            err_rd !== 5'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: size=%0h addr=%0h rd=%0d err_rd=%0d data=%0h required 0",
                     out_heap_size, out_heap_addr, out_rd, err_rd, out_data);
        end
        do_reset();
    endtask

    task automatic test_push_pop();
        do_reset();
        enq(2'b00, 5'd3, 32'h55);
        checks++;
        if (out_v !== 1'b0) begin
            errors++;
            $display("FAIL push_latency: out_v=%b required 0 at accept edge", out_v);
        end
        @(negedge clk);
        checks++;
        if (out_v !== 1'b1 || out_rd !== 5'd3 || out_vrd1 !== 3'b000 || out_vrd2 !== 3'b000) begin
            errors++;
            $display("FAIL push_issue: v=%b rd=%0d vrd1=%b vrd2=%b required 1 3 000 000",
                     out_v, out_rd, out_vrd1, out_vrd2);
        end
        checks++;
        if (out_heap_size !== 32'd0 || out_data !== 32'h55 || err_v !== 1'b0) begin
            errors++;
            $display("FAIL push_fields: size=%0d data=%0h err_v=%b required 0 55 0",
                     out_heap_size, out_data, err_v);
        end
        @(negedge clk);
        checks++;
        if (out_v !== 1'b0) begin
            errors++;
            $display("FAIL push_pulse: out_v=%b required 0", out_v);
        end
        ret_pulse();
        enq(2'b01, 5'd4, 32'hdead);
        @(negedge clk);
        checks++;
        if (out_v !== 1'b1 || out_vrd1 !== 3'b001 || out_heap_size !== 32'd1 ||
            out_data !== 32'd0 || out_rd !== 5'd4) begin
            errors++;
            $display("FAIL pop_issue: v=%b vrd1=%b size=%0d data=%0h rd=%0d required 1 001 1 0 4",
                     out_v, out_vrd1, out_heap_size, out_data, out_rd);
        end
        ret_pulse();
    endtask

    task automatic test_pop_empty();
        do_reset();
        enq(2'b01, 5'd7, 32'd0);
        @(negedge clk);
        checks++;
        if (err_v !== 1'b1 || err_rd !== 5'd7 || out_v !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty: err_v=%b err_rd=%0d out_v=%b required 1 7 0",
                     err_v, err_rd, out_v);
        end
        @(negedge clk);
        checks++;
        if (err_v !== 1'b0 || dut.r_inflight !== 3'd0) begin
            errors++;
            $display("FAIL pop_empty_after: err_v=%b inflight=%0d required 0 0",
                     err_v, dut.r_inflight);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        for (int i = 0; i < 5; i++) enq(2'b00, 5'(10 + i), 32'(i + 1));
        repeat (4) @(negedge clk);
        checks++;
        if (mon_issue !== 4 || out_v !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL credit_stall: issued=%0d out_v=%b busy=%b required 4 0 1",
                     mon_issue, out_v, busy);
        end
        ret_pulse();
        repeat (3) @(negedge clk);
        checks++;
        if (mon_issue !== 5 || mon_size !== 32'd4 || mon_rd !== 5'd14 || mon_data !== 32'd5) begin
            errors++;
            $display("FAIL credit_release: issued=%0d size=%0d rd=%0d data=%0h required 5 4 14 5",
                     mon_issue, mon_size, mon_rd, mon_data);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        enq(2'b00, 5'd1, 32'h1);
        enq(2'b00, 5'd2, 32'h2);
        enq(2'b00, 5'd3, 32'h3);
        ret_v = 1'b1;
        @(negedge clk);
        ret_v = 1'b0;
        checks++;
        if (dut.r_inflight !== 3'd2 || out_v !== 1'b1 || out_heap_size !== 32'd2) begin
            errors++;
            $display("FAIL ret_and_issue: inflight=%0d out_v=%b size=%0d required 2 1 2",
                     dut.r_inflight, out_v, out_heap_size);
        end
        ret_pulse();
        ret_pulse();
        ret_pulse();
        checks++;
        if (dut.r_inflight !== 3'd0) begin
            errors++;
            $display("FAIL ret_at_zero: inflight=%0d required 0", dut.r_inflight);
        end
    endtask

    task automatic test_setbase();
        do_reset();
        enq(2'b00, 5'd1, 32'hA);
        enq(2'b00, 5'd2, 32'hB);
        enq(2'b10, 5'd0, 32'h1000);
        enq(2'b00, 5'd20, 32'hC);
        repeat (5) @(negedge clk);
        checks++;
        if (mon_issue !== 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL setbase_wait: issued=%0d busy=%b required 2 1", mon_issue, busy);
        end
        ret_pulse();
        repeat (3) @(negedge clk);
        checks++;
        if (mon_issue !== 2) begin
            errors++;
            $display("FAIL setbase_wait2: issued=%0d required 2", mon_issue);
        end
        ret_pulse();
        repeat (6) @(negedge clk);
        checks++;
        if (mon_issue !== 3 || mon_addr !== 32'h1000 || mon_size !== 32'd0 || mon_rd !== 5'd20) begin
            errors++;
            $display("FAIL setbase_push: issued=%0d addr=%0h size=%0d rd=%0d required 3 1000 0 20",
                     mon_issue, mon_addr, mon_size, mon_rd);
        end
        ret_pulse();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL setbase_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_fifo_full();
        bit accepted;
        do_reset();
        for (int i = 0; i < 8; i++) enq(2'b00, 5'(i), 32'(16 + i));
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: cmd_ready=%b required 0", cmd_ready);
        end
        cmd_v    = 1'b1;
        cmd_op   = 2'b01;
        cmd_rd   = 5'd9;
        cmd_data = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || mon_issue !== 4) begin
            errors++;
            $display("FAIL full_hold: cmd_ready=%b issued=%0d required 0 4", cmd_ready, mon_issue);
        end
        ret_pulse();
        accepted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!accepted) begin
                if (cmd_ready) accepted = 1'b1;
                @(negedge clk);
            end
        end
        cmd_v = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL full_accept: cmd_ready never rose within 8 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            ret_pulse();
            @(negedge clk);
        end
        checks++;
        if (mon_issue !== 9 || mon_rd !== 5'd9 || mon_vrd1 !== 3'b001 || mon_size !== 32'd8) begin
            errors++;
            $display("FAIL full_fifth: issued=%0d rd=%0d vrd1=%b size=%0d required 9 9 001 8",
                     mon_issue, mon_rd, mon_vrd1, mon_size);
        end
    endtask

    task automatic test_cap_limit();
        // Continues from test_fifo_full: size 7, nothing in flight.
        enq(2'b00, 5'd21, 32'h7);
        repeat (2) @(negedge clk);
        ret_pulse();
        enq(2'b00, 5'd22, 32'h8);
        @(negedge clk);
        checks++;
        if (err_v !== 1'b1 || err_rd !== 5'd22 || out_v !== 1'b0) begin
            errors++;
            $display("FAIL cap_err: err_v=%b err_rd=%0d out_v=%b required 1 22 0",
                     err_v, err_rd, out_v);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mon_issue !== 10 || mon_size !== 32'd7 || mon_err !== 1 || dut.r_inflight !== 3'd0) begin
            errors++;
            $display("FAIL cap_state: issued=%0d size=%0d errs=%0d inflight=%0d required 10 7 1 0",
                     mon_issue, mon_size, mon_err, dut.r_inflight);
        end
        checks++;
        if (mon_excl !== 0) begin
            errors++;
            $display("FAIL out_err_exclusive: overlap cycles=%0d required 0", mon_excl);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_credit_limit();
        test_same_cycle();
        test_setbase();
        test_fifo_full();
        test_cap_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/heap_op_dispatch.md
HEAP_OP_DISPATCH -- requirements
Module: heap_op_dispatch

Interface
REQ-001 The block SHALL have parameter PIPE_CYCLES, default 4: maximum heap ops in flight in the downstream heap unit.
REQ-002 The block SHALL have parameter QDEPTH, default 4: command FIFO depth, a power of two of at least 2.
REQ-003 The block SHALL have parameter HEAP_CAP, default 1024: heap capacity in words.
REQ-004 The block SHALL have the ports listed below, clock and reset first.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cmd_v  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_v and cmd_ready are both high at a clk edge.
- cmd_op  in  2  command: 00 push, 01 pop, 10 set-base, 11 nop.
- cmd_rd  in  5  destination register tag.
- cmd_data  in  32  push data, or new base address for set-base.
- out_v  out  1  heap op valid to the heap unit.
- out_rd  out  5  tag.
- out_vrd1  out  3  heap opcode: 000 push, 001 pop.
- out_vrd2  out  3  always 000.
- out_data  out  32  push data; 0 for pop.
- out_heap_addr  out  32  current base.
- out_heap_size  out  32  size before this op.
- ret_v  in  1  heap unit completion pulse; returns one credit.
- err_v  out  1  one-cycle error pulse.
- err_rd  out  5  tag of the rejected op.
- busy  out  1  high when the FIFO is non-empty, credits are outstanding, or the FSM is not in RUN.

Function
REQ-005 cmd_ready SHALL equal !fifo_full; an enqueue does not happen in a cycle where the FIFO is full, even if the same cycle dequeues.
REQ-006 An accepted command SHALL be written to the FIFO at edge N; the earliest out_v or err_v for it is at edge N+1. All outputs are registered.
REQ-007 At most one FIFO entry SHALL be dequeued per cycle, in order.
REQ-008 The FSM SHALL have three states: RUN, DRAIN and SETBASE.
REQ-009 In RUN, the head push or pop SHALL issue when inflight < PIPE_CYCLES; otherwise it waits with out_v low and the head retained.
REQ-010 A push with size == HEAP_CAP, or a pop with size == 0, SHALL NOT issue; it is dequeued with err_v=1 and err_rd=tag, consumes no credit, and leaves size unchanged. The credit limit does not apply.
REQ-011 A valid push SHALL issue with out_heap_size = size and set size to size+1; a valid pop SHALL issue with out_heap_size = size and set size to size-1.
REQ-012 A nop SHALL be dequeued with no output.
REQ-013 A set-base at the head SHALL move RUN to DRAIN, with no further dequeue.
REQ-014 DRAIN SHALL move to SETBASE once inflight == 0.
REQ-015 SETBASE SHALL load base from cmd_data, set size to 0, dequeue the entry, and return to RUN, taking one cycle.
REQ-016 inflight SHALL increment on issue and decrement on ret_v; when both happen in the same cycle it is unchanged.
REQ-017 A ret_v received while inflight == 0 SHALL be ignored; inflight never wraps.
REQ-018 The FIFO pointers SHALL wrap modulo QDEPTH; full and empty are distinguished by an occupancy counter.
REQ-019 out_v and err_v SHALL never be high in the same cycle.

Reset
REQ-020 On reset, all outputs SHALL go to 0 except cmd_ready, which goes to 1.
REQ-021 On reset, FIFO, inflight, size and base SHALL clear and the FSM SHALL enter RUN.
REQ-022 A reset asserted mid-drain SHALL discard all queued and in-flight bookkeeping; ret_v pulses arriving after reset are ignored per REQ-017.

Configuration
REQ-023 With macro HEAP_DISPATCH_STATS_EN defined, the block SHALL provide outputs stat_push[31:0], stat_pop[31:0] and stat_err[31:0], each counting its event, wrapping at 2^32, and cleared by reset.
REQ-024 Without HEAP_DISPATCH_STATS_EN, those ports SHALL still exist but be tied to 0, with no counter logic.

Verification
REQ-025 Reset, then push(rd=3, data=0x55) -> one cycle later out_v=1, out_vrd1=000, out_heap_size=0, out_data=0x55; size becomes 1.
REQ-026 Pop on an empty heap, rd=7 -> err_v=1, err_rd=7, out_v=0, no credit taken.
REQ-027 Five pushes, no ret_v, PIPE_CYCLES=4 -> four issue; the fifth waits until one ret_v, then issues with out_heap_size=4.
REQ-028 Two pushes, set-base 0x1000, push -> the set-base waits for two ret_v pulses; the final push issues with out_heap_addr=0x1000 and out_heap_size=0.
REQ-029 QDEPTH=4 full with cmd_v held high -> cmd_ready=0; the fifth command is not lost and is accepted once a slot frees.
REQ-030 ret_v and issue in the same cycle with inflight=2 -> inflight stays 2; ret_v while inflight=0 -> inflight stays 0.
